fetch: RTL

- Instruction fetch stage that sits directly upstream of the opcode decoder.
- Loads the PC from the reset vector, reads opcode and operand bytes over the single-port byte bus, and computes instruction length from the 6502 opcode layout.
- Presents one complete instruction (opcode, operand, PC, length) to the decode/execute stage over a valid/ready handshake.
- Accepts PC redirects from branch/jump/interrupt logic.

---
 rtl/fetch.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fetch.sv
// 6502-style fetch stage: reset vector load, opcode/operand byte reads,
// length decode and a valid/ready instruction bundle for decode.
module fetch #(
  parameter logic [15:0] RESET_VEC = 16'hFFFC,
  parameter bit          VEC_FETCH = 1'b1,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_rdy,
  input  logic        redir_valid,
  input  logic [15:0] redir_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_opcode,
  output logic [15:0] out_operand,
  output logic [1:0]  out_len,
  output logic [15:0] out_pc
);

  typedef enum logic [2:0] {
    VEC_LO, VEC_HI, VEC_DONE, OPC, B1, B2, B3, HOLD
  } state_t;

  localparam state_t RST_STATE =
    state_t'(VEC_FETCH ? VEC_LO : OPC);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [15:0] operand_q, operand_d;
  logic [1:0]  len_q, len_d;
  logic [15:0] opc_pc_q, opc_pc_d;
  logic [15:0] pc_inc1, pc_inc2;
  logic        in_vec;

  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic one, three;
    one = (op == 8'h00) || (op == 8'h40) || (op == 8'h60)
       || (op[3:2] == 2'b10 && !op[0]);
    three = (op == 8'h20) || (op[3:2] == 2'b11)
         || (op[4:2] == 3'b110 && op[0]);
    if (one)        return 2'd1;
    else if (three) return 2'd3;
    else            return 2'd2;
  endfunction

  assign pc_inc1 = pc_q + 16'd1;
  assign pc_inc2 = pc_q + 16'd2;
  assign in_vec  = (state_q == VEC_LO) || (state_q == VEC_HI)
                || (state_q == VEC_DONE);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    len_d     = len_q;
    opc_pc_d  = opc_pc_q;
    mem_addr  = pc_q;
    mem_rd    = 1'b0;
    unique case (state_q)
      VEC_LO: begin
        mem_addr = RESET_VEC;
        mem_rd   = 1'b1;
        if (mem_rdy) state_d = VEC_HI;
      end
      VEC_HI: begin
        mem_addr = RESET_VEC + 16'd1;
        mem_rd   = 1'b1;
        if (mem_rdy) begin
          pc_d[7:0] = mem_rdata;
          state_d   = VEC_DONE;
        end
      end
      VEC_DONE: begin
        if (mem_rdy) begin
          pc_d[15:8] = mem_rdata;
          state_d    = OPC;
        end
      end
      OPC: begin
        mem_rd = 1'b1;
        if (mem_rdy) state_d = B1;
      end
      B1: begin
        // second byte is read even for 1-byte opcodes
        mem_addr = pc_inc1;
        mem_rd   = 1'b1;
        if (mem_rdy) begin
          opcode_d = mem_rdata;
          len_d    = op_len(mem_rdata);
          opc_pc_d = pc_q;
          state_d  = B2;
        end
      end
      B2: begin
        mem_addr = pc_inc2;
        mem_rd   = (len_q == 2'd3);
        if (mem_rdy) begin
          operand_d = {8'h00, (len_q == 2'd1) ? 8'h00 : mem_rdata};
          state_d   = (len_q == 2'd3) ? B3 : HOLD;
          valid_d   = (len_q != 2'd3);
        end
      end
      B3: begin
        if (mem_rdy) begin
          operand_d[15:8] = mem_rdata;
          state_d         = HOLD;
          valid_d         = 1'b1;
        end
      end
      HOLD: begin
        if (mem_rdy && out_ready) begin
          pc_d    = pc_q + {14'd0, len_q};
          valid_d = 1'b0;
          state_d = OPC;
        end
      end
      default: state_d = RST_STATE;
    endcase
    // redirect overrides both the fetch sequence and a same-cycle handshake
    if (redir_valid && !in_vec) begin
      state_d = OPC;
      pc_d    = redir_pc;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      opcode_q  <= 8'h00;
      operand_q <= 16'h0000;
      len_q     <= 2'd0;
      opc_pc_q  <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      len_q     <= len_d;
      opc_pc_q  <= opc_pc_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_opcode  = opcode_q;
  assign out_operand = operand_q;
  assign out_len     = len_q;
  assign out_pc      = opc_pc_q;

endmodule
